exhaustive_vector_checker: RTL and testbench

- Synthesisable, parametrised successor to the 4-input exhaustive truth-table benches.
- Drives all 2^N_IN input vectors into a combinational DUT in ascending order and waits SETTLE cycles per vector.
- Samples the DUT's 1-bit output, compares it against the expected truth table EXP_TT, counts mismatches and records the first failing vector.
- Sits beside the DUT in on-chip self-test wrappers and in regression benches; replaces the hand-written vector lists.

---
 rtl/exhaustive_vector_checker.sv | 155 +++++++++++++++
 tb/tb_exhaustive_vector_checker.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exhaustive_vector_checker.sv
// Exhaustive truth-table sweeper: drives every input vector into a combinational DUT,
// compares its 1-bit response with EXP_TT and reports errors. `define SIG_MISR_EN adds a 16-bit MISR signature.
module exhaustive_vector_checker #(
  parameter int unsigned               N_IN   = 4,
  parameter int unsigned               SETTLE = 1,
  parameter logic [(1 << N_IN) - 1:0]  EXP_TT = 16'h6996
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] vec,
  input  logic            dut_o,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic            fail_seen,
  output logic [N_IN-1:0] first_fail
`ifdef SIG_MISR_EN
  ,
  output logic [15:0]     sig
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] SETTLE_C = 8'(SETTLE);

  state_t          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [N_IN:0]   err_q, err_d, err_inc;
  logic            fs_q, fs_d;
  logic [N_IN-1:0] ff_q, ff_d;
  logic            pass_q, pass_d;
  logic            done_q, done_d;
  logic            mismatch;
  logic            sample;
`ifdef SIG_MISR_EN
  logic [15:0]     sig_q, sig_d, sig_upd;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fs_q    <= 1'b0;
      ff_q    <= '0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SIG_MISR_EN
      sig_q   <= 16'hFFFF;
`endif
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fs_q    <= fs_d;
      ff_q    <= ff_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
`ifdef SIG_MISR_EN
      sig_q   <= sig_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    fs_d     = fs_q;
    ff_d     = ff_q;
    pass_d   = pass_q;
    done_d   = 1'b0;
    mismatch = (dut_o != EXP_TT[vec_q]);
    sample   = (state_q == RUN) && (cnt_q == SETTLE_C);
    // Includes the current sample so a last-vector mismatch is seen by pass.
    err_inc  = err_q + (N_IN + 1)'(mismatch);
`ifdef SIG_MISR_EN
    sig_d    = sig_q;
    sig_upd  = {sig_q[14:0], 1'b0} ^ ((sig_q[15] ^ dut_o) ? 16'h1021 : 16'h0000);
`endif

    if (abort) begin
      state_d = IDLE;
      vec_d   = '0;
      cnt_d   = '0;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d = RUN;
            vec_d   = '0;
            cnt_d   = '0;
            err_d   = '0;
            fs_d    = 1'b0;
            ff_d    = '0;
            pass_d  = 1'b0;
`ifdef SIG_MISR_EN
            sig_d   = 16'hFFFF;
`endif
          end
        end
        RUN: begin
          if (sample) begin
            if (mismatch) begin
              err_d = err_inc;
              if (!fs_q) begin
                fs_d = 1'b1;
                ff_d = vec_q;
              end
            end
`ifdef SIG_MISR_EN
            sig_d = sig_upd;
`endif
            if (vec_q == '1) begin
              state_d = DONE;
              done_d  = 1'b1;
              pass_d  = (err_inc == '0);
            end else begin
              vec_d = vec_q + N_IN'(1);
              cnt_d = '0;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign vec        = vec_q;
  assign busy       = (state_q == RUN);
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign fail_seen  = fs_q;
  assign first_fail = ff_q;
`ifdef SIG_MISR_EN
  assign sig        = sig_q;
`endif

endmodule

// File: tb/tb_exhaustive_vector_checker.sv
// Directed bench for exhaustive_vector_checker: three instances (defaults, SETTLE=0, N_IN=2 AND).
module tb_exhaustive_vector_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, abort_a = 1'b0;
  logic start_b = 1'b0, abort_b = 1'b0;
  logic start_c = 1'b0, abort_c = 1'b0;
  logic [3:0] vec_a, ff_a, vec_b, ff_b;
  logic [1:0] vec_c, ff_c;
  logic [4:0] err_a, err_b;
  logic [2:0] err_c;
  logic busy_a, done_a, pass_a, fs_a, dut_a;
  logic busy_b, done_b, pass_b, fs_b, dut_b;
  logic busy_c, done_c, pass_c, fs_c, dut_c;
`ifdef SIG_MISR_EN
  logic [15:0] sig_a, sig_b, sig_c;
`endif
  int mode_a = 0;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Mode 1 models a broken XOR that inverts vectors 5 and 11.
  assign dut_a = (^vec_a) ^ ((mode_a == 1) && (vec_a == 4'd5 || vec_a == 4'd11));
  assign dut_b = 1'b0;
  assign dut_c = &vec_c;

  exhaustive_vector_checker #(.N_IN(4), .SETTLE(1), .EXP_TT(16'h6996)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .vec(vec_a), .dut_o(dut_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a), .fail_seen(fs_a), .first_fail(ff_a)
`ifdef SIG_MISR_EN
    , .sig(sig_a)
`endif
  );

  exhaustive_vector_checker #(.N_IN(4), .SETTLE(0), .EXP_TT(16'h6996)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .vec(vec_b), .dut_o(dut_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b), .fail_seen(fs_b), .first_fail(ff_b)
`ifdef SIG_MISR_EN
    , .sig(sig_b)
`endif
  );

  exhaustive_vector_checker #(.N_IN(2), .SETTLE(1), .EXP_TT(4'b1000)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .abort(abort_c), .vec(vec_c), .dut_o(dut_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .err_cnt(err_c), .fail_seen(fs_c), .first_fail(ff_c)
`ifdef SIG_MISR_EN
    , .sig(sig_c)
`endif
  );

`ifdef SIG_MISR_EN
  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic b);
    return {s[14:0], 1'b0} ^ ((s[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction
`endif

  // Pulses start_a for one edge; returns at the negedge just after the start edge.
  task automatic kick_a();
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
  endtask

  task automatic wait_done_a(output int cyc);
    cyc = 0;
    while (!done_a && cyc < 200) begin
      @(negedge clk); cyc++;
    end
  endtask

  task automatic test_reset();
    #1;
    n_tests++; if (vec_a !== 4'd0)  begin n_fail++; $display("FAIL rst_vec: got %0d expected 0", vec_a); end
    n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy_a); end
    n_tests++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b expected 0", done_a); end
    n_tests++; if (pass_a !== 1'b0) begin n_fail++; $display("FAIL rst_pass: got %b expected 0", pass_a); end
    n_tests++; if (err_a !== 5'd0 || fs_a !== 1'b0 || ff_a !== 4'd0)
      begin n_fail++; $display("FAIL rst_results: got err=%0d fs=%b ff=%0d expected 0/0/0", err_a, fs_a, ff_a); end
`ifdef SIG_MISR_EN
    n_tests++; if (sig_a !== 16'hFFFF) begin n_fail++; $display("FAIL rst_sig: got %h expected ffff", sig_a); end
`endif
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_pass();
    int cyc, bad;
    mode_a = 0;
    kick_a();
    cyc = 0; bad = 0;
    while (!done_a && cyc < 200) begin
      if (vec_a !== 4'(cyc / 2) || busy_a !== 1'b1) bad++;
      @(negedge clk); cyc++;
    end
    n_tests++; if (cyc != 32) begin n_fail++; $display("FAIL pass_latency: got %0d cycles expected 32", cyc); end
    n_tests++; if (bad != 0)  begin n_fail++; $display("FAIL pass_vec_seq: got %0d bad cycles expected 0", bad); end
    n_tests++; if (busy_a !== 1'b0 || pass_a !== 1'b1)
      begin n_fail++; $display("FAIL pass_flags: got busy=%b pass=%b expected 0/1", busy_a, pass_a); end
    n_tests++; if (err_a !== 5'd0 || fs_a !== 1'b0)
      begin n_fail++; $display("FAIL pass_err: got err=%0d fs=%b expected 0/0", err_a, fs_a); end
    @(negedge clk);
    n_tests++; if (done_a !== 1'b0 || vec_a !== 4'd15)
      begin n_fail++; $display("FAIL pass_done_hold: got done=%b vec=%0d expected 0/15", done_a, vec_a); end
  endtask

  task automatic test_mismatch();
    int dones;
    mode_a = 1;
    kick_a();
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_a === 1'b1) dones++;
      @(negedge clk);
    end
    n_tests++; if (dones != 1)   begin n_fail++; $display("FAIL mm_done_count: got %0d expected 1", dones); end
    n_tests++; if (err_a !== 5'd2) begin n_fail++; $display("FAIL mm_err: got %0d expected 2", err_a); end
    n_tests++; if (ff_a !== 4'd5 || fs_a !== 1'b1)
      begin n_fail++; $display("FAIL mm_first: got ff=%0d fs=%b expected 5/1", ff_a, fs_a); end
    n_tests++; if (pass_a !== 1'b0) begin n_fail++; $display("FAIL mm_pass: got %b expected 0", pass_a); end
  endtask

  task automatic test_settle0();
    int cyc;
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    cyc = 0;
    while (!done_b && cyc < 200) begin
      @(negedge clk); cyc++;
    end
    n_tests++; if (cyc != 16) begin n_fail++; $display("FAIL s0_latency: got %0d cycles expected 16", cyc); end
    n_tests++; if (err_b !== 5'd8) begin n_fail++; $display("FAIL s0_err: got %0d expected 8", err_b); end
    n_tests++; if (ff_b !== 4'd1 || fs_b !== 1'b1 || pass_b !== 1'b0)
      begin n_fail++; $display("FAIL s0_first: got ff=%0d fs=%b pass=%b expected 1/1/0", ff_b, fs_b, pass_b); end
  endtask

  task automatic test_abort();
    int cyc, dones;
    mode_a = 1;
    kick_a();
    cyc = 0;
    while (vec_a !== 4'd7 && cyc < 100) begin
      @(negedge clk); cyc++;
    end
    n_tests++; if (vec_a !== 4'd7) begin n_fail++; $display("FAIL ab_reach7: got vec=%0d expected 7", vec_a); end
    abort_a = 1'b1;
    @(negedge clk); abort_a = 1'b0;
    n_tests++; if (busy_a !== 1'b0 || vec_a !== 4'd0 || pass_a !== 1'b0 || done_a !== 1'b0)
      begin n_fail++; $display("FAIL ab_state: got busy=%b vec=%0d pass=%b done=%b expected 0/0/0/0", busy_a, vec_a, pass_a, done_a); end
    n_tests++; if (err_a !== 5'd1 || ff_a !== 4'd5 || fs_a !== 1'b1)
      begin n_fail++; $display("FAIL ab_partial: got err=%0d ff=%0d fs=%b expected 1/5/1", err_a, ff_a, fs_a); end
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_a === 1'b1 || busy_a === 1'b1) dones++;
      @(negedge clk);
    end
    n_tests++; if (dones != 0) begin n_fail++; $display("FAIL ab_no_done: got %0d active cycles expected 0", dones); end
    start_a = 1'b1; abort_a = 1'b1;
    @(negedge clk); start_a = 1'b0; abort_a = 1'b0;
    n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL ab_priority: got busy=%b expected 0", busy_a); end
    mode_a = 0;
    kick_a();
    n_tests++; if (err_a !== 5'd0 || fs_a !== 1'b0 || vec_a !== 4'd0 || busy_a !== 1'b1)
      begin n_fail++; $display("FAIL ab_restart: got err=%0d fs=%b vec=%0d busy=%b expected 0/0/0/1", err_a, fs_a, vec_a, busy_a); end
    wait_done_a(cyc);
    n_tests++; if (cyc != 32 || pass_a !== 1'b1)
      begin n_fail++; $display("FAIL ab_resweep: got cyc=%0d pass=%b expected 32/1", cyc, pass_a); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    mode_a = 1;
    kick_a();
    cyc = 0;
    while (vec_a !== 4'd9 && cyc < 100) begin
      @(negedge clk); cyc++;
    end
    rst_n = 1'b0;
    #1;
    n_tests++; if (vec_a !== 4'd0 || busy_a !== 1'b0 || done_a !== 1'b0 || pass_a !== 1'b0)
      begin n_fail++; $display("FAIL rm_ctrl: got vec=%0d busy=%b done=%b pass=%b expected 0/0/0/0", vec_a, busy_a, done_a, pass_a); end
    n_tests++; if (err_a !== 5'd0 || fs_a !== 1'b0 || ff_a !== 4'd0)
      begin n_fail++; $display("FAIL rm_results: got err=%0d fs=%b ff=%0d expected 0/0/0", err_a, fs_a, ff_a); end
    @(negedge clk); rst_n = 1'b1;
    mode_a = 0;
    kick_a();
    wait_done_a(cyc);
    n_tests++; if (cyc != 32 || pass_a !== 1'b1 || err_a !== 5'd0)
      begin n_fail++; $display("FAIL rm_resweep: got cyc=%0d pass=%b err=%0d expected 32/1/0", cyc, pass_a, err_a); end
  endtask

  task automatic test_back_to_back();
    int cyc, t1, t2;
    logic p1, p2;
`ifdef SIG_MISR_EN
    logic [15:0] s1, s2, s_exp;
`endif
    t1 = -1; t2 = -1; p1 = 1'b0; p2 = 1'b0;
`ifdef SIG_MISR_EN
    s1 = '0; s2 = '0;
`endif
    @(negedge clk); start_c = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (t2 < 0 && cyc < 60) begin
      if (done_c === 1'b1) begin
        if (t1 < 0) begin
          t1 = cyc; p1 = pass_c;
`ifdef SIG_MISR_EN
          s1 = sig_c;
`endif
        end else begin
          t2 = cyc; p2 = pass_c;
`ifdef SIG_MISR_EN
          s2 = sig_c;
`endif
        end
      end
      @(negedge clk); cyc++;
    end
    start_c = 1'b0;
    n_tests++; if (t1 != 8) begin n_fail++; $display("FAIL b2b_first: got %0d expected 8", t1); end
    // Spacing is sweep length plus the single DONE cycle in which start is re-sampled.
    n_tests++; if (t2 - t1 != 9) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected 9", t2 - t1); end
    n_tests++; if (p1 !== 1'b1 || p2 !== 1'b1)
      begin n_fail++; $display("FAIL b2b_pass: got %b/%b expected 1/1", p1, p2); end
`ifdef SIG_MISR_EN
    s_exp = 16'hFFFF;
    for (int k = 0; k < 4; k++) s_exp = misr_step(s_exp, k == 3);
    n_tests++; if (s1 !== s2) begin n_fail++; $display("FAIL b2b_sig_equal: got %h/%h expected equal", s1, s2); end
    n_tests++; if (s1 !== s_exp) begin n_fail++; $display("FAIL b2b_sig_value: got %h expected %h", s1, s_exp); end
`endif
    repeat (20) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_pass();
    test_mismatch();
    test_settle0();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
